// File: rtl/mem_access.sv
// rtl/mem_access.sv - single-outstanding load/store unit between pipeline and data bus
// Handles alignment faults, byte-lane steering and load extension; flush kills the result, not the bus cycle.
module mem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err,
  output logic        err_store,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_sext;
  logic        killed;

  logic        misaligned;
  logic        accept;
  logic        complete;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      default: misaligned = |req_addr[1:0];
    endcase
  end

  assign accept   = (state == IDLE) && req_valid && !flush && !misaligned;
  assign complete = ((state == ADDR) && data_addr_ok && data_data_ok) ||
                    ((state == DATA) && data_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = ADDR;
      ADDR: begin
        if (data_addr_ok) begin
          state_next = data_data_ok ? DONE : DATA;
        end
      end
      DATA: if (data_data_ok) state_next = DONE;
      DONE: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    resp_valid = 1'b0;
    addr_err   = 1'b0;
    err_store  = 1'b0;
    data_req   = 1'b0;
    case (state)
      IDLE: begin
        stall     = accept;
        addr_err  = req_valid && !flush && misaligned;
        err_store = req_valid && !flush && misaligned && req_we;
      end
      ADDR: begin
        stall    = 1'b1;
        data_req = 1'b1;
      end
      DATA: stall = 1'b1;
      DONE: resp_valid = !killed;
    endcase
  end

  always_comb begin
    load_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: load_byte = data_rdata[7:0];
      2'd1: load_byte = data_rdata[15:8];
      2'd2: load_byte = data_rdata[23:16];
      2'd3: load_byte = data_rdata[31:24];
    endcase
    load_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (r_size)
      2'd0:    load_value = r_sext ? {{24{load_byte[7]}}, load_byte} : {24'h000000, load_byte};
      2'd1:    load_value = r_sext ? {{16{load_half[15]}}, load_half} : {16'h0000, load_half};
      default: load_value = data_rdata;
    endcase
  end

  // A flush arriving in the completing cycle must also suppress the result update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_size     <= 2'd0;
      r_we       <= 1'b0;
      r_sext     <= 1'b0;
      killed     <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      if (accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_we    <= req_we;
        r_sext  <= req_sext;
      end
      if (state == DONE) begin
        killed <= 1'b0;
      end else if (((state == ADDR) || (state == DATA)) && flush) begin
        killed <= 1'b1;
      end
      if (complete && !r_we && !(killed || flush)) begin
        resp_rdata <= load_value;
      end
    end
  end

  always_comb begin
    data_wstrb = 4'b0000;
    if (r_we) begin
      case (r_size)
        2'd0:    data_wstrb = 4'b0001 << r_addr[1:0];
        2'd1:    data_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (r_size)
      2'd0:    data_wdata = {4{r_wdata[7:0]}};
      2'd1:    data_wdata = {2{r_wdata[15:0]}};
      default: data_wdata = r_wdata;
    endcase
  end

  assign data_wr   = r_we;
  assign data_size = r_size;
  assign data_addr = r_addr;

endmodule
